// File: rtl/starflux_pkg.sv
// Shared screen geometry, bus widths and the draw FSM state type.
package starflux_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search req from ptr upward with wrap.
// The result is one-hot, or all-zero when nothing is requesting.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner
);

  // First set request at or after ptr, modulo N, wins.
  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned idx;
      idx = (32'(ptr) + i) % N;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_arbiter.sv
// Shares the VGA plot port between sprite requesters. A round-robin winner
// gets its rectangle drawn one pixel per clock in raster order, off-screen
// pixels suppressed, followed by a one-cycle done pulse.
module sprite_draw_arbiter
  import starflux_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SPR_W   = 8,
  parameter int unsigned SPR_H   = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*X_W-1:0]      req_x,
  input  logic [NUM_REQ*Y_W-1:0]      req_y,
  input  logic [NUM_REQ*COLOUR_W-1:0] req_colour,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic                        busy,
  output logic                        plot,
  output logic [X_W-1:0]              vga_x,
  output logic [Y_W-1:0]              vga_y,
  output logic [COLOUR_W-1:0]         vga_colour
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 4;

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q;
  logic [PTR_W-1:0]      win_q, ptr_q;
  logic [X_W-1:0]        base_x_q;
  logic [Y_W-1:0]        base_y_q;
  logic [COLOUR_W-1:0]   colour_q;
  logic [CNT_W-1:0]      col_q, row_q;

  logic [NUM_REQ-1:0]    win_onehot;
  logic [PTR_W-1:0]      win_idx;
  logic                  col_last, last_pix;
  logic [X_W:0]          sum_x;
  logic [Y_W:0]          sum_y;

  rr_arbiter #(
    .N    (NUM_REQ),
    .PTR_W(PTR_W)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (ptr_q),
    .winner(win_onehot)
  );

  // Encode the one-hot winner into an index for slicing and pointer update.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) win_idx = PTR_W'(i);
    end
  end

  assign col_last = (col_q == CNT_W'(SPR_W - 1));
  assign last_pix = col_last && (row_q == CNT_W'(SPR_H - 1));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: grant on any request, draw a fixed pixel count, one done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = DRAW;
      DRAW:    if (last_pix) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, raster counters and round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q  <= '0;
      win_q    <= '0;
      ptr_q    <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      colour_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q  <= win_onehot;
            win_q    <= win_idx;
            base_x_q <= req_x[win_idx*X_W +: X_W];
            base_y_q <= req_y[win_idx*Y_W +: Y_W];
            colour_q <= req_colour[win_idx*COLOUR_W +: COLOUR_W];
            col_q    <= '0;
            row_q    <= '0;
          end
        end
        DRAW: begin
          if (col_last) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        DONE: begin
          grant_q <= '0;
          ptr_q   <= (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        end
        default: grant_q <= '0;
      endcase
    end
  end

  // Pixel address with one extra bit so off-screen sums do not wrap.
  assign sum_x = {1'b0, base_x_q} + (X_W + 1)'(col_q);
  assign sum_y = {1'b0, base_y_q} + (Y_W + 1)'(row_q);

  // Outputs decoded purely from registered state.
  always_comb begin
    plot       = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    if (state_q == DRAW) begin
      plot       = (sum_x < (X_W + 1)'(SCREEN_W)) && (sum_y < (Y_W + 1)'(SCREEN_H));
      vga_x      = sum_x[X_W-1:0];
      vga_y      = sum_y[Y_W-1:0];
      vga_colour = colour_q;
    end
  end

  assign grant = grant_q;
  assign done  = (state_q == DONE) ? grant_q : '0;
  assign busy  = (state_q != IDLE);

endmodule
